// File: rtl/wb_port_arbiter.sv
// Write-back arbiter: four one-entry slot buffers share two register-file write
// ports through a rotating-priority scan. Tag-0 entries are dropped without using a port.
module wb_port_arbiter #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a0_wb_vld,
    input  logic [TAG_W-1:0]  a0_wb_tag,
    input  logic [DATA_W-1:0] a0_wb_data,
    output logic              a0_wb_rdy,
    input  logic              a1_wb_vld,
    input  logic [TAG_W-1:0]  a1_wb_tag,
    input  logic [DATA_W-1:0] a1_wb_data,
    output logic              a1_wb_rdy,
    input  logic              m_wb_vld,
    input  logic [TAG_W-1:0]  m_wb_tag,
    input  logic [DATA_W-1:0] m_wb_data,
    output logic              m_wb_rdy,
    input  logic              ls_wb_vld,
    input  logic [TAG_W-1:0]  ls_wb_tag,
    input  logic [DATA_W-1:0] ls_wb_data,
    output logic              ls_wb_rdy,
    output logic              wp0_en,
    output logic [TAG_W-1:0]  wp0_tag,
    output logic [DATA_W-1:0] wp0_data,
    output logic              wp1_en,
    output logic [TAG_W-1:0]  wp1_tag,
    output logic [DATA_W-1:0] wp1_data,
    output logic              wb_busy
);
    localparam int N_SLOTS = 4;

    logic [N_SLOTS-1:0] w_in_vld;
    logic [TAG_W-1:0]   w_in_tag   [N_SLOTS];
    logic [DATA_W-1:0]  w_in_data  [N_SLOTS];
    logic [N_SLOTS-1:0] w_rdy;

    logic [N_SLOTS-1:0] w_full;
    logic [N_SLOTS-1:0] w_cand;
    logic [N_SLOTS-1:0] w_discard;
    logic [N_SLOTS-1:0] w_grant;
    logic [TAG_W-1:0]   w_buf_tag  [N_SLOTS];
    logic [DATA_W-1:0]  w_buf_data [N_SLOTS];
    logic [1:0]         w_scan_idx [N_SLOTS];

    logic [1:0] r_ptr;
    logic       w_p0_hit;
    logic       w_p1_hit;
    logic [1:0] w_p0_idx;
    logic [1:0] w_p1_idx;

    // Slot order A0=0, A1=1, M=2, LS=3.
    assign w_in_vld     = {ls_wb_vld, m_wb_vld, a1_wb_vld, a0_wb_vld};
    assign w_in_tag[0]  = a0_wb_tag;
    assign w_in_tag[1]  = a1_wb_tag;
    assign w_in_tag[2]  = m_wb_tag;
    assign w_in_tag[3]  = ls_wb_tag;
    assign w_in_data[0] = a0_wb_data;
    assign w_in_data[1] = a1_wb_data;
    assign w_in_data[2] = m_wb_data;
    assign w_in_data[3] = ls_wb_data;
    assign a0_wb_rdy    = w_rdy[0];
    assign a1_wb_rdy    = w_rdy[1];
    assign m_wb_rdy     = w_rdy[2];
    assign ls_wb_rdy    = w_rdy[3];

    genvar gi;
    generate
        for (gi = 0; gi < N_SLOTS; gi++) begin : g_slot
            logic              r_full;
            logic [TAG_W-1:0]  r_tag;
            logic [DATA_W-1:0] r_data;
            logic              w_take;

            assign w_scan_idx[gi] = r_ptr + 2'(gi);
            assign w_cand[gi]     = r_full && (r_tag != '0);
            assign w_discard[gi]  = r_full && (r_tag == '0);
            assign w_grant[gi]    = w_discard[gi]
                                 || (w_p0_hit && (w_p0_idx == 2'(gi)))
                                 || (w_p1_hit && (w_p1_idx == 2'(gi)));
            // A buffer draining this cycle may accept its next result on the same edge.
            assign w_rdy[gi]      = !rst && (!r_full || w_grant[gi]);
            assign w_take         = w_in_vld[gi] && w_rdy[gi];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_full <= 1'b0;
                end else if (w_take) begin
                    r_full <= 1'b1;
                    r_tag  <= w_in_tag[gi];
                    r_data <= w_in_data[gi];
                end else if (w_grant[gi]) begin
                    r_full <= 1'b0;
                end
            end

            assign w_full[gi]     = r_full;
            assign w_buf_tag[gi]  = r_tag;
            assign w_buf_data[gi] = r_data;
        end
    endgenerate

    // Second port skips any candidate aiming at the same register as port 0.
    always_comb begin
        w_p0_hit = 1'b0;
        w_p0_idx = '0;
        w_p1_hit = 1'b0;
        w_p1_idx = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            if (w_cand[w_scan_idx[k]]) begin
                if (!w_p0_hit) begin
                    w_p0_hit = 1'b1;
                    w_p0_idx = w_scan_idx[k];
                end else if (!w_p1_hit
                             && (w_buf_tag[w_scan_idx[k]] != w_buf_tag[w_p0_idx])) begin
                    w_p1_hit = 1'b1;
                    w_p1_idx = w_scan_idx[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_p1_hit) begin
            r_ptr <= w_p1_idx + 2'd1;
        end else if (w_p0_hit) begin
            r_ptr <= w_p0_idx + 2'd1;
        end
    end

    assign wp0_en   = w_p0_hit && !rst;
    assign wp0_tag  = wp0_en ? w_buf_tag[w_p0_idx]  : '0;
    assign wp0_data = wp0_en ? w_buf_data[w_p0_idx] : '0;
    assign wp1_en   = w_p1_hit && !rst;
    assign wp1_tag  = wp1_en ? w_buf_tag[w_p1_idx]  : '0;
    assign wp1_data = wp1_en ? w_buf_data[w_p1_idx] : '0;
    assign wb_busy  = (|w_full) && !rst;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed vector table, hand sequences, then random
// traffic checked against a scan-list reference model.
module tb_wb_port_arbiter;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 5;

    logic              clk;
    logic              rst;
    logic [3:0]        vld;
    logic [TAG_W-1:0]  tag [4];
    logic [DATA_W-1:0] dat [4];
    logic              a0_rdy, a1_rdy, m_rdy, ls_rdy;
    logic              wp0_en, wp1_en, wb_busy;
    logic [TAG_W-1:0]  wp0_tag, wp1_tag;
    logic [DATA_W-1:0] wp0_data, wp1_data;
    logic [3:0]        rdy_vec;

    int errors = 0;
    int checks = 0;

    wb_port_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .a0_wb_vld(vld[0]), .a0_wb_tag(tag[0]), .a0_wb_data(dat[0]), .a0_wb_rdy(a0_rdy),
        .a1_wb_vld(vld[1]), .a1_wb_tag(tag[1]), .a1_wb_data(dat[1]), .a1_wb_rdy(a1_rdy),
        .m_wb_vld(vld[2]),  .m_wb_tag(tag[2]),  .m_wb_data(dat[2]),  .m_wb_rdy(m_rdy),
        .ls_wb_vld(vld[3]), .ls_wb_tag(tag[3]), .ls_wb_data(dat[3]), .ls_wb_rdy(ls_rdy),
        .wp0_en(wp0_en), .wp0_tag(wp0_tag), .wp0_data(wp0_data),
        .wp1_en(wp1_en), .wp1_tag(wp1_tag), .wp1_data(wp1_data),
        .wb_busy(wb_busy)
    );

    assign rdy_vec = {ls_rdy, m_rdy, a1_rdy, a0_rdy};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic                  rst;
        logic [3:0]            vld;
        logic [3:0][TAG_W-1:0] tag;
        logic [3:0]            rdy;
        logic                  busy;
        logic                  e0;
        logic [1:0]            s0;
        logic [TAG_W-1:0]      t0;
        logic                  e1;
        logic [1:0]            s1;
        logic [TAG_W-1:0]      t1;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [DATA_W-1:0] data_of(int s, logic [TAG_W-1:0] t);
        return 32'hD000_0000 | (32'(s) << 8) | 32'(t);
    endfunction

    function automatic vec_t mk(logic r, logic [3:0] v, int ta0, int ta1, int tm, int tls,
                                logic [3:0] rd, logic bz, int p0s, int p0t, int p1s, int p1t);
        vec_t x;
        x.rst    = r;
        x.vld    = v;
        x.tag[0] = 5'(ta0);
        x.tag[1] = 5'(ta1);
        x.tag[2] = 5'(tm);
        x.tag[3] = 5'(tls);
        x.rdy    = rd;
        x.busy   = bz;
        x.e0     = (p0s >= 0);
        x.s0     = (p0s >= 0) ? 2'(p0s) : 2'd0;
        x.t0     = 5'(p0t);
        x.e1     = (p1s >= 0);
        x.s1     = (p1s >= 0) ? 2'(p1s) : 2'd0;
        x.t1     = 5'(p1t);
        return x;
    endfunction

    task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        vld = '0;
        for (int s = 0; s < 4; s++) begin
            tag[s] = '0;
            dat[s] = '0;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Reference model state
    logic [3:0]        m_full;
    logic [TAG_W-1:0]  m_tag  [4];
    logic [DATA_W-1:0] m_data [4];
    int                m_ptr;
    int                order[$];
    logic [3:0]        pend;
    logic [TAG_W-1:0]  p_tag  [4];
    logic [DATA_W-1:0] p_data [4];

    initial begin
        int cnt [4];
        int run [4];
        int maxrun;
        logic [80:0] got_v, exp_v;

        rst = 1'b1;
        idle_inputs();

        // Directed vectors; each row is one cycle, tags listed A0,A1,M,LS
        tbl.push_back(mk(1, 4'h0, 0, 0, 0, 0, 4'h0, 0, -1, 0, -1, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 4'hF, 0, -1, 0, -1, 0));
        tbl.push_back(mk(0, 4'hF, 1, 2, 3, 4, 4'hF, 0, -1, 0, -1, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 4'h3, 1,  0, 1,  1, 2));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 4'hF, 1,  2, 3,  3, 4));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 4'hF, 0, -1, 0, -1, 0));
        tbl.push_back(mk(0, 4'hC, 0, 0, 0, 7, 4'hF, 0, -1, 0, -1, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 4'hF, 1,  3, 7, -1, 0));
        tbl.push_back(mk(0, 4'hA, 0, 5, 0, 6, 4'hF, 0, -1, 0, -1, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 4'hF, 1,  1, 5,  3, 6));
        tbl.push_back(mk(0, 4'h3, 9, 9, 0, 0, 4'hF, 0, -1, 0, -1, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 4'hD, 1,  0, 9, -1, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 4'hF, 1,  1, 9, -1, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 4'hF, 0, -1, 0, -1, 0));
        tbl.push_back(mk(0, 4'h7, 1, 2, 3, 0, 4'hF, 0, -1, 0, -1, 0));
        tbl.push_back(mk(1, 4'h0, 0, 0, 0, 0, 4'h0, 0, -1, 0, -1, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 4'hF, 0, -1, 0, -1, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 4'hF, 0, -1, 0, -1, 0));

        foreach (tbl[i]) begin
            rst = tbl[i].rst;
            vld = tbl[i].vld;
            for (int s = 0; s < 4; s++) begin
                tag[s] = tbl[i].tag[s];
                dat[s] = data_of(s, tbl[i].tag[s]);
            end
            #1;
            chk($sformatf("vec%0d_rdy", i), 128'(rdy_vec), 128'(tbl[i].rdy));
            chk($sformatf("vec%0d_busy", i), 128'(wb_busy), 128'(tbl[i].busy));
            chk($sformatf("vec%0d_wp0", i), 128'({wp0_en, wp0_tag, wp0_data}),
                128'(tbl[i].e0 ? {1'b1, tbl[i].t0, data_of(int'(tbl[i].s0), tbl[i].t0)} : 38'd0));
            chk($sformatf("vec%0d_wp1", i), 128'({wp1_en, wp1_tag, wp1_data}),
                128'(tbl[i].e1 ? {1'b1, tbl[i].t1, data_of(int'(tbl[i].s1), tbl[i].t1)} : 38'd0));
            tick();
        end
        $display("directed vectors applied: %0d rows", tbl.size());

        // Single result with latency check
        do_reset();
        vld[0] = 1'b1;
        tag[0] = 5'd3;
        dat[0] = 32'hDEAD_0001;
        #1;
        chk("single_rdy_c0", 128'(a0_rdy), 128'(1));
        tick();
        idle_inputs();
        #1;
        chk("single_wp0_c1", 128'({wp0_en, wp0_tag, wp0_data}), 128'({1'b1, 5'd3, 32'hDEAD_0001}));
        chk("single_wp1_c1", 128'(wp1_en), 128'(0));
        chk("single_busy_c1", 128'(wb_busy), 128'(1));
        tick();
        #1;
        chk("single_busy_c2", 128'(wb_busy), 128'(0));
        $display("single result sequence done");

        // Fairness: every slot offers a result every cycle
        do_reset();
        for (int s = 0; s < 4; s++) begin
            cnt[s] = 0;
            run[s] = 0;
        end
        maxrun = 0;
        for (int c = 0; c <= 8; c++) begin
            vld = 4'hF;
            for (int s = 0; s < 4; s++) begin
                tag[s] = 5'(s + 1);
                dat[s] = data_of(s, 5'(s + 1));
            end
            #1;
            if (c >= 1) begin
                chk($sformatf("fair_pair_c%0d", c), 128'({wp0_en, wp0_tag, wp1_en, wp1_tag}),
                    128'((c % 2 == 1) ? {1'b1, 5'd1, 1'b1, 5'd2} : {1'b1, 5'd3, 1'b1, 5'd4}));
                if (wp0_en && wp0_tag >= 5'd1 && wp0_tag <= 5'd4) cnt[int'(wp0_tag) - 1]++;
                if (wp1_en && wp1_tag >= 5'd1 && wp1_tag <= 5'd4) cnt[int'(wp1_tag) - 1]++;
            end
            for (int s = 0; s < 4; s++) begin
                run[s] = rdy_vec[s] ? 0 : run[s] + 1;
                if (run[s] > maxrun) maxrun = run[s];
            end
            tick();
        end
        idle_inputs();
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("fair_grants_slot%0d", s), 128'(cnt[s]), 128'(4));
        end
        checks++;
        if (maxrun > 1) begin
            errors++;
            $display("FAIL fair_rdy_low_run: got=%0d required<=1", maxrun);
        end
        $display("fairness sequence done");
        tick();
        tick();
        tick();

        // Random traffic against the reference model
        do_reset();
        m_full = '0;
        m_ptr  = 0;
        pend   = '0;
        for (int s = 0; s < 4; s++) begin
            m_tag[s]  = '0;
            m_data[s] = '0;
            p_tag[s]  = '0;
            p_data[s] = '0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            int g0, g1, nptr;
            logic [3:0] served, exp_rdy;
            logic [DATA_W-1:0] d0, d1;
            logic [TAG_W-1:0] t0, t1;

            rst = ($urandom_range(0, 59) == 0);
            for (int s = 0; s < 4; s++) begin
                if (!pend[s] && $urandom_range(0, 2) != 0) begin
                    pend[s]   = 1'b1;
                    p_tag[s]  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    p_data[s] = $urandom;
                end
                vld[s] = pend[s];
                tag[s] = pend[s] ? p_tag[s]  : 5'($urandom);
                dat[s] = pend[s] ? p_data[s] : $urandom;
            end

            // Ordered candidate list starting at the pointer
            order.delete();
            for (int k = 0; k < 4; k++) begin
                int s;
                s = (m_ptr + k) % 4;
                if (m_full[s] && m_tag[s] != 0) order.push_back(s);
            end
            g0 = -1;
            g1 = -1;
            if (order.size() > 0) g0 = order[0];
            for (int i = 1; i < order.size(); i++) begin
                if (g1 < 0 && m_tag[order[i]] != m_tag[g0]) g1 = order[i];
            end
            for (int s = 0; s < 4; s++) begin
                served[s]  = m_full[s] && (m_tag[s] == 0 || s == g0 || s == g1);
                exp_rdy[s] = !rst && (!m_full[s] || served[s]);
            end
            t0 = (g0 >= 0 && !rst) ? m_tag[g0]  : '0;
            d0 = (g0 >= 0 && !rst) ? m_data[g0] : '0;
            t1 = (g1 >= 0 && !rst) ? m_tag[g1]  : '0;
            d1 = (g1 >= 0 && !rst) ? m_data[g1] : '0;
            exp_v = {(g0 >= 0 && !rst), t0, d0, (g1 >= 0 && !rst), t1, d1, exp_rdy,
                     (m_full != 0) && !rst};

            #1;
            got_v = {wp0_en, wp0_tag, wp0_data, wp1_en, wp1_tag, wp1_data, rdy_vec, wb_busy};
            chk($sformatf("rand_c%0d", cyc), 128'(got_v), 128'(exp_v));

            if (rst) begin
                m_full = '0;
                m_ptr  = 0;
            end else begin
                nptr = (g1 >= 0) ? (g1 + 1) % 4 : (g0 >= 0) ? (g0 + 1) % 4 : m_ptr;
                for (int s = 0; s < 4; s++) begin
                    if (pend[s] && exp_rdy[s]) begin
                        m_full[s] = 1'b1;
                        m_tag[s]  = p_tag[s];
                        m_data[s] = p_data[s];
                        pend[s]   = 1'b0;
                    end else if (served[s]) begin
                        m_full[s] = 1'b0;
                    end
                end
                m_ptr = nptr;
            end
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        $display("random phase done: 400 cycles");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Write-back arbiter that shares the two register-file write ports among the four execution slots (A0, A1, M, LS). It sits between the execute/memory stages and the register file. Each slot owns a one-entry holding buffer with a valid/ready handshake, and a rotating-priority scheduler grants at most two buffered results per cycle. The block stalls a slot only when that slot's buffer is occupied and not granted.

## Interface
- DATA_W, 32, result data width
- TAG_W, 5, destination register tag width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- a0_wb_vld / a1_wb_vld / m_wb_vld / ls_wb_vld  in  1 each  slot presents a result
- a0_wb_tag / a1_wb_tag / m_wb_tag / ls_wb_tag  in  TAG_W each  destination register
- a0_wb_data / a1_wb_data / m_wb_data / ls_wb_data  in  DATA_W each  result value
- a0_wb_rdy / a1_wb_rdy / m_wb_rdy / ls_wb_rdy  out  1 each  slot may hand over a result this cycle
- wp0_en, wp1_en  out  1 each  register-file write port strobes
- wp0_tag, wp1_tag  out  TAG_W each  write addresses
- wp0_data, wp1_data  out  DATA_W each  write data
- wb_busy  out  1  any holding buffer occupied

## Operation
- Slot index order: A0=0, A1=1, M=2, LS=3. Each slot has a holding buffer {full, tag, data}.
- Transfer: on a cycle where vld & rdy are both high, the buffer captures tag and data and sets full.
- Ready: rdy = ~full | granted_this_cycle, so a full buffer drained this cycle can refill in the same cycle. A full buffer that is not granted holds its contents. vld without rdy is ignored. The slot must hold vld, tag and data stable until rdy.
- Candidates: buffers with full=1 and tag≠0.
- Tag 0: a buffer with full=1 and tag=0 is a discard. It clears the following edge without using a port and behaves as granted for rdy.
- Scheduler: a 2-bit rotating pointer ptr.
  - Scan candidates in order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - The first candidate found drives wp0. The next candidate whose tag differs from the wp0 tag drives wp1.
  - A same-tag second candidate is deferred. The decoder scoreboard guarantees at most one outstanding write per tag, so this case is a protective fallback.
- Pointer update: ptr <= (index of last port grant + 1) mod 4. If there is no port grant, ptr is unchanged. Discards do not move ptr.
- A granted buffer clears full on the edge, unless it refills in the same cycle.
- Write-port outputs are combinational from buffer state and ptr. When a port is unused, its en=0, tag=0 and data=0.
- wb_busy = OR of all full bits.

## Timing
- Latency: a result accepted at edge N is visible on a write port in cycle N+1 at the earliest, and written at edge N+2.
- Throughput: 2 writes per cycle sustained. Four slots each issuing every cycle therefore stall on average half the time.
- Starvation bound: a full buffer is granted within 2 cycles of becoming the oldest waiting candidate.
- Reset (rst high at an edge):
  - State: all full cleared, ptr=0.
  - While rst is high: wp0_en=wp1_en=0, all rdy=0, wb_busy=0.
  - Cycle after rst falls: all rdy=1.
- Reset mid-operation: buffered results are dropped, with no write-port activity. This is legal only on pipeline flush.
- Simultaneous events:
  - A grant and a new capture on the same buffer in one cycle: the new entry wins the edge.
  - rst overrides every capture and grant.

## Test plan
- Single result: A0 vld, tag=3, data=0xDEAD0001 at cycle 0, others idle.
  - a0_wb_rdy=1 in cycle 0.
  - Cycle 1: wp0_en=1, wp0_tag=3, wp0_data=0xDEAD0001, wp1_en=0, wb_busy=1.
  - Cycle 2: wb_busy=0.
- Full contention: all four slots vld once in cycle 0, tags 1/2/3/4, ptr=0.
  - Cycle 1: wp0 tag 1 and wp1 tag 2; A0 and A1 rdy return high.
  - Cycle 2: tags 3 and 4, ptr=0 afterward.
- Fairness: all four slots vld every cycle for 8 cycles.
  - Each slot receives exactly 4 port grants.
  - Grant pairs alternate {A0,A1} and {M,LS}.
  - No rdy stays low for more than 1 consecutive cycle.
- Tag-0 discard: M vld, tag=0, with LS vld, tag=7.
  - Cycle 1: wp0 tag 7 only, wp1_en=0.
  - M buffer empty at cycle 2; ptr=0 after the cycle.
- Same-tag fallback: A0 and A1 both tag=9 in cycle 0.
  - Cycle 1: wp0 = A0 entry, wp1_en=0, a1_wb_rdy=0.
  - Cycle 2: wp0 = A1 entry.
- Reset mid-operation: three buffers full, rst high for one cycle.
  - That cycle and the next: no write-port enables.
  - wb_busy=0 and all rdy=1 in the cycle after rst falls.
